// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART buffer definitions: default geometry and the byte type used by
// both the receive-side and transmit-side buffers.
package uart_rx_buffer_pkg;

  localparam int UART_RXBUF_DEPTH  = 16;
  localparam int UART_RXBUF_ADDR_W = 4;

  typedef logic [7:0] uart_byte_t;

endpackage : uart_rx_buffer_pkg

// File: rtl/uart_rx_buffer_if.sv
// Bundle of receiver-side strobes and CPU-side status for the receive buffer.
// The master drives the strobes; the slave (the buffer) drives status.
interface uart_rx_buffer_if
  import uart_rx_buffer_pkg::*;
#(
  parameter int ADDR_W = UART_RXBUF_ADDR_W
);

  logic            i_Rx_DV;
  uart_byte_t      i_Rx_Byte;
  logic            i_Rd;
  logic            i_Clr_Ovf;
  uart_byte_t      o_Data;
  logic            o_Empty;
  logic            o_Full;
  logic [ADDR_W:0] o_Count;
  logic            o_Overflow;
  logic            o_Irq;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Rd, i_Clr_Ovf,
    input  o_Data, o_Empty, o_Full, o_Count, o_Overflow, o_Irq
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Rd, i_Clr_Ovf,
    output o_Data, o_Empty, o_Full, o_Count, o_Overflow, o_Irq
  );

endinterface : uart_rx_buffer_if

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage with a synchronous write port and an asynchronous read
// port. Contents are deliberately not reset.
module uart_fifo_ram
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = UART_RXBUF_DEPTH,
  parameter int ADDR_W = UART_RXBUF_ADDR_W
) (
  input  logic              i_Clock,
  input  logic              i_Wr_En,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  uart_byte_t        i_Wr_Data,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output uart_byte_t        o_Rd_Data
);

  uart_byte_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem_q[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO between the UART receiver and CPU I/O: show-ahead
// head byte, occupancy flags, sticky overflow and a per-byte interrupt pulse.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = UART_RXBUF_DEPTH,
  parameter int ADDR_W = UART_RXBUF_ADDR_W
) (
  input  logic             i_Clock,
  input  logic             reset,
  uart_rx_buffer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;

  logic              empty_s, full_s, push_s, pop_s, wr_en_s;
  uart_byte_t        rd_data_s;

  assign empty_s = (count_q == {(ADDR_W + 1){1'b0}});
  assign full_s  = (count_q == CNT_FULL);
  assign pop_s   = bus.i_Rd && !empty_s;
  // A full buffer still takes a byte when a pop frees the head slot that cycle.
  assign push_s  = bus.i_Rx_DV && (!full_s || pop_s);
  assign wr_en_s = push_s && !reset;

  // Next-state for pointers, occupancy, overflow and interrupt
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_d      = 1'b0;
    if (reset) begin
      wr_ptr_d   = {ADDR_W{1'b0}};
      rd_ptr_d   = {ADDR_W{1'b0}};
      count_d    = {(ADDR_W + 1){1'b0}};
      overflow_d = 1'b0;
      irq_d      = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (bus.i_Rx_DV && !push_s) begin
        overflow_d = 1'b1;
      end else if (bus.i_Clr_Ovf) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end
      irq_d = push_s;
    end
  end

  // State registers
  always_ff @(posedge i_Clock) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
    irq_q      <= irq_d;
  end

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_Clock   (i_Clock),
    .i_Wr_En   (wr_en_s),
    .i_Wr_Addr (wr_ptr_q),
    .i_Wr_Data (bus.i_Rx_Byte),
    .i_Rd_Addr (rd_ptr_q),
    .o_Rd_Data (rd_data_s)
  );

  assign bus.o_Data     = empty_s ? 8'h00 : rd_data_s;
  assign bus.o_Empty    = empty_s;
  assign bus.o_Full     = full_s;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = overflow_q;
  assign bus.o_Irq      = irq_q;

endmodule : uart_rx_buffer

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with a queue scoreboard of expected bytes.
module tb_uart_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic i_Clock = 1'b0;
  logic reset   = 1'b1;

  uart_rx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock (i_Clock),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 i_Clock = ~i_Clock;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb_q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_irq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_data;
    exp_data = (sb_q.size() == 0) ? 8'h00 : sb_q[0];
    chk({tag, ".count"}, 32'(bus.o_Count), 32'(sb_q.size()));
    chk({tag, ".empty"}, 32'(bus.o_Empty), 32'(sb_q.size() == 0));
    chk({tag, ".full"},  32'(bus.o_Full),  32'(sb_q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(bus.o_Overflow), 32'(exp_ovf));
    chk({tag, ".irq"},   32'(bus.o_Irq),   32'(exp_irq));
    chk({tag, ".data"},  32'(bus.o_Data),  32'(exp_data));
  endtask

  // One clock: drive strobes at the negedge, model the expected effect, check after the edge.
  task automatic cycle(input string tag, input logic dv, input logic [7:0] b,
                       input logic rd, input logic clr);
    logic pop_ok, push_ok, was_full;
    logic [7:0] got;
    pop_ok   = rd && (sb_q.size() != 0);
    was_full = (sb_q.size() == DEPTH);
    push_ok  = dv && (!was_full || pop_ok);
    if (pop_ok) begin
      got = sb_q.pop_front();
      chk({tag, ".popped"}, 32'(bus.o_Data), 32'(got));
    end
    if (push_ok) sb_q.push_back(b);
    if (dv && !push_ok) exp_ovf = 1'b1;
    else if (clr)       exp_ovf = 1'b0;
    exp_irq = push_ok;
    bus.i_Rx_DV   = dv;
    bus.i_Rx_Byte = b;
    bus.i_Rd      = rd;
    bus.i_Clr_Ovf = clr;
    @(posedge i_Clock);
    @(negedge i_Clock);
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Rd      = 1'b0;
    bus.i_Clr_Ovf = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset         = 1'b1;
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'hEE;
    bus.i_Rd      = 1'b1;
    bus.i_Clr_Ovf = 1'b0;
    @(posedge i_Clock);
    @(negedge i_Clock);
    reset         = 1'b0;
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rd      = 1'b0;
    sb_q.delete();
    exp_ovf = 1'b0;
    exp_irq = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Rd      = 1'b0;
    bus.i_Clr_Ovf = 1'b0;
    @(negedge i_Clock);
    do_reset("reset");

    cycle("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("idle_a5", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("pop_a5",  1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle("ovf_77",    1'b1, 8'h77, 1'b0, 1'b0);
    cycle("clr_ovf",   1'b0, 8'h00, 1'b0, 1'b1);
    cycle("ovf_set_clr", 1'b1, 8'h78, 1'b0, 1'b1);
    cycle("clr_ovf2",  1'b0, 8'h00, 1'b0, 1'b1);

    cycle("full_push_pop", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain55", 1'b0, 8'h00, 1'b1, 1'b0);

    cycle("empty_push_pop", 1'b1, 8'h3C, 1'b1, 1'b0);
    cycle("pop_3c",   1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 8'(8'h40 + i), (i % 3) != 0, 1'b0);
    for (int i = 0; i < 8; i++)  cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pre_reset_ovf", 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset("mid_reset");
    cycle("push_12", 1'b1, 8'h12, 1'b0, 1'b0);
    cycle("pop_12",  1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx_buffer

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte FIFO that sits directly downstream of the UART receiver, between the receiver and the CPU memory-mapped I/O. Captures every one-cycle data-valid byte strobe from the receiver into a power-of-two circular buffer so the CPU can drain bytes at its own pace. Provides a show-ahead head byte, occupancy and status flags, a sticky overflow flag, and a per-byte interrupt pulse.

## Interface
- DEPTH, 16: buffer entries; power of two, 2..256.
- ADDR_W, 4: log2(DEPTH); pointer width.
- i_Clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- i_Rx_DV  in  1  one-cycle strobe from the receiver; byte on i_Rx_Byte is valid in the same cycle.
- i_Rx_Byte  in  8  received byte.
- i_Rd  in  1  pop strobe from the CPU I/O decoder; one byte is popped per high cycle.
- i_Clr_Ovf  in  1  clears o_Overflow.
- o_Data  out  8  oldest stored byte (show-ahead); 8'h00 when empty.
- o_Empty  out  1  count == 0.
- o_Full  out  1  count == DEPTH.
- o_Count  out  ADDR_W+1  number of stored bytes, 0..DEPTH.
- o_Overflow  out  1  sticky; a byte was dropped because the buffer was full.
- o_Irq  out  1  registered one-cycle pulse per accepted byte.

## Operation
- State: wr_ptr and rd_ptr (ADDR_W bits, wrap modulo DEPTH), count (ADDR_W+1 bits), overflow flag, irq register, storage array.
- Push accepted when i_Rx_DV && (!full || pop accepted in the same cycle): write mem[wr_ptr], wr_ptr+1.
- Pop accepted when i_Rd && !empty: rd_ptr+1. Pop on an empty buffer is ignored; pointers and count unchanged.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full + push + pop in the same cycle: both accepted, count stays DEPTH, no overflow.
- Empty + push + pop in the same cycle: push accepted, pop ignored, count becomes 1.
- Full + push without pop: byte dropped, pointers unchanged, o_Overflow set to 1.
- o_Overflow clears on i_Clr_Ovf. Clear and set in the same cycle: set wins.
- o_Irq = 1 in the cycle after each accepted push; otherwise 0.
- o_Data = mem[rd_ptr] when !empty, else 8'h00. This is an asynchronous read of the storage array.
- Pointer wrap: DEPTH−1 → 0 with no special handling.
- Storage array is not cleared by reset. Its contents are never visible while empty.

## Timing
- Reset values: o_Data 8'h00, o_Empty 1, o_Full 0, o_Count 0, o_Overflow 0, o_Irq 0. Pointers 0.
- Reset mid-operation discards all stored bytes and the overflow flag at that edge. An i_Rx_DV or i_Rd in the reset cycle is ignored.
- Push latency: byte strobed at edge N is visible on o_Data after edge N (if the buffer was empty). o_Count, o_Empty and o_Full also update after edge N. o_Irq is high for the cycle following edge N.
- Pop latency: i_Rd sampled at edge N; the next byte, or 8'h00, is on o_Data after edge N. The CPU reads o_Data before or in the same cycle as asserting i_Rd.
- i_Rd held for K cycles pops min(K, count) bytes. The I/O decoder must present i_Rd as a single-cycle strobe per CPU read.
- Back-to-back i_Rx_DV on consecutive cycles is supported, although the receiver never produces it.

## Structure
- Shared package: UART_RXBUF_DEPTH = 16 and UART_RXBUF_ADDR_W = 4 defaults, and the 8-bit byte type, shared with the transmitter-side buffer.
- One sub-module: uart_fifo_ram. It is a DEPTH×8 array with a synchronous write port and an asynchronous read port, reusable by the transmit buffer.
- Pointer, count, flag and irq logic stays in uart_rx_buffer.

## Test plan
- Reset, then push 0xA5 -> next cycle: o_Data = 0xA5, o_Count = 1, o_Empty = 0, o_Irq pulses for one cycle. Pop -> o_Empty = 1, o_Data = 0x00.
- Push 0x00..0x0F (DEPTH = 16) -> o_Full = 1, o_Count = 16. Pop 16 times -> bytes come out in order 0x00..0x0F, then o_Empty = 1.
- Fill to 16, then push 0x77 -> o_Overflow = 1, 0x77 is dropped, count stays 16, no o_Irq. Assert i_Clr_Ovf -> o_Overflow = 0.
- Full buffer, push 0x55 and pop in the same cycle -> count stays 16, no overflow, 0x55 emerges last.
- Empty buffer, push 0x3C and i_Rd in the same cycle -> count = 1, o_Data = 0x3C. Pop on empty -> no change.
- Push 20 bytes while popping to exercise pointer wrap, assert reset mid-stream -> all outputs return to reset values. The next push 0x12 appears on o_Data.
